mem_dma_engine: RTL and testbench
=================================

Name: mem_dma_engine

Overview:
Command-driven initiator for the 256x16 single-port memory array, which has a combinational read and a write on the clock edge when enabled. It accepts one command at a time: fill, block copy, single read or single write. It sequences the memory's addr/Din/en pins and returns read data. It sits between a control FSM or CPU and the memory.

Parameters:
AW, 8, memory address width (256 words); addresses wrap modulo 2^AW
DW, 16, memory data width
LW, 9, length field width; holds 0..256

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
op  in  2  command: 0=FILL, 1=COPY, 2=RD, 3=WR
src  in  AW  source start address (COPY, RD)
dst  in  AW  destination start address (FILL, COPY, WR)
len  in  LW  word count for FILL/COPY; ignored for RD/WR
wdata  in  DW  fill value (FILL) or write value (WR)
busy  out  1  high from the cycle after start is accepted through the DONE cycle
done  out  1  one-cycle completion pulse
rdata  out  DW  RD result; holds until the next RD completes
mem_addr  out  AW  to memory addr
mem_din  out  DW  to memory Din
mem_en  out  1  to memory write enable
mem_dout  in  DW  from memory Dout (combinational read)

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - busy=0, done=0, rdata=0, mem_en=0, mem_addr=0, mem_din=0.
  - Reset mid-command aborts with no done pulse. Words already written stay written.
- Command capture:
  - In IDLE with start=1, latch op, src, dst, len and wdata at the edge.
  - Initialise src_ptr, dst_ptr and remaining count.
  - start while busy is ignored, with no queuing.
- mem_en is 1 only in FILL, WRITE and SWR states. It is 0 in every other state, including IDLE and DONE.
- States:
  - IDLE:
    - Outputs mem_en=0, mem_addr=0, mem_din=0.
    - start with FILL/COPY and len=0 -> DONE (no memory access).
    - FILL -> FILL; COPY -> READ; RD -> SRD; WR -> SWR.
  - FILL:
    - Drives mem_addr=dst_ptr, mem_din=fill value, mem_en=1.
    - Each cycle: dst_ptr+1, count-1.
    - After the last word -> DONE.
    - N words take N cycles.
  - READ:
    - Drives mem_addr=src_ptr, mem_en=0.
    - Captures mem_dout into the buffer at the edge; src_ptr+1.
    - -> WRITE.
  - WRITE:
    - Drives mem_addr=dst_ptr, mem_din=buffer, mem_en=1.
    - Each cycle: dst_ptr+1, count-1.
    - If count reaches 0 -> DONE, else -> READ.
    - COPY of N words takes 2N cycles.
  - SRD: drives mem_addr=src; captures mem_dout into rdata at the edge; -> DONE.
  - SWR: drives mem_addr=dst, mem_din=wdata, mem_en=1 for one cycle; -> DONE.
  - DONE: done=1, busy=1, mem_en=0; -> IDLE unconditionally.
- Latency: the next command can be accepted in the cycle after DONE. The start-to-done edge count is:
  - FILL: N+1
  - COPY: 2N+1
  - RD/WR: 2
  - len=0: 1
- Wrap-around: pointers increment modulo 256. Example: FILL dst=0xFE, len=4 writes 0xFE, 0xFF, 0x00, 0x01.
- len is clamped: len>256 is treated as 256.
- Overlap: COPY is strictly forward, one read then one write per word.
  - With dst>src and overlapping ranges, earlier writes are re-read. This replication is the defined behaviour.
  - src==dst rewrites identical data.
- All arithmetic is unsigned. Count is LW bits wide.

Decomposition:
- Shared package holds:
  - opcode constants OP_FILL=2'd0, OP_COPY=2'd1, OP_RD=2'd2, OP_WR=2'd3
  - state encoding IDLE, FILL, READ, WRITE, SRD, SWR, DONE
  - AW/DW defaults
- Single module; no sub-module is needed. The memory array is instantiated beside the engine at the top level and on the bench.

Test Plan:
- WR dst=0x10, wdata=0xA5A5, then RD src=0x10 -> one mem_en cycle at addr 0x10; rdata=0xA5A5 with done; busy low afterwards.
- FILL dst=0x20, len=8, wdata=0x1234 -> exactly 8 consecutive mem_en cycles at addrs 0x20..0x27; done on the 9th edge; 0x1F and 0x28 unchanged.
- Preload 0x40..0x43 = 1, 2, 3, 4; COPY src=0x40, dst=0x80, len=4 -> 0x80..0x83 = 1, 2, 3, 4; mem_en alternates 0/1 over 8 cycles; done at edge 9.
- FILL dst=0xFE, len=4, wdata=0x00FF -> 0xFE, 0xFF, 0x00, 0x01 written; 0x02 untouched. Then FILL len=0 -> done after 1 edge with no mem_en.
- Overlap: preload 0x00=7; FILL 0x01..0x03 = 0; COPY src=0x00, dst=0x01, len=3 -> 0x01..0x03 all = 7.
- Assert rst mid-COPY (after 2 words, len=6) -> outputs zero immediately with no done; only 2 dst words are changed. A start pulse during busy is ignored.

Source files
------------

// File: rtl/mem_dma_engine_pkg.sv
// mem_dma_engine_pkg
// Shared definitions for the memory DMA engine.
// Contents: default address/data/length widths, the command opcodes and
// the engine state encoding.
package mem_dma_engine_pkg;

  localparam int AW_DEF = 8;   // 256-word memory
  localparam int DW_DEF = 16;  // 16-bit words
  localparam int LW_DEF = 9;   // length field holds 0..256

  localparam logic [1:0] OP_FILL = 2'd0;
  localparam logic [1:0] OP_COPY = 2'd1;
  localparam logic [1:0] OP_RD   = 2'd2;
  localparam logic [1:0] OP_WR   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_SRD   = 3'd4,
    ST_SWR   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/mem_dma_engine.sv
// mem_dma_engine
// Command-driven initiator for a single-port memory with combinational read
// and clocked write. Executes one command at a time: FILL, COPY, RD or WR.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, op           command strobe (sampled in IDLE only) and opcode
//   src, dst, len       source/destination start addresses, word count
//   wdata               fill value (FILL) or write value (WR)
//   busy, done          command in progress / one-cycle completion pulse
//   rdata               result of the last RD command
//   mem_addr, mem_din,
//   mem_en, mem_dout    memory interface (address, write data, write
//                       enable, combinational read data)
module mem_dma_engine
  import mem_dma_engine_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_en,
  input  logic [DW-1:0] mem_dout
);

  // Largest meaningful transfer: the whole memory.
  localparam logic [LW-1:0] MAX_LEN = LW'(2 ** AW);

  state_t        state_r, state_nx_s;
  logic [AW-1:0] src_ptr_r, dst_ptr_r;
  logic [LW-1:0] cnt_r, len_clamp_s;
  logic [DW-1:0] wval_r, buf_r, rdata_r;

  // Clamp the requested length to the memory size.
  always_comb begin
    len_clamp_s = len;
    if (len > MAX_LEN) begin
      len_clamp_s = MAX_LEN;
    end else begin
      len_clamp_s = len;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_FILL: state_nx_s = (len_clamp_s == {LW{1'b0}}) ? ST_DONE : ST_FILL;
            OP_COPY: state_nx_s = (len_clamp_s == {LW{1'b0}}) ? ST_DONE : ST_READ;
            OP_RD:   state_nx_s = ST_SRD;
            OP_WR:   state_nx_s = ST_SWR;
            default: state_nx_s = ST_IDLE;
          endcase
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      // cnt_r == 1 means the word being written this cycle is the last one.
      ST_FILL:  state_nx_s = (cnt_r == LW'(1)) ? ST_DONE : ST_FILL;
      ST_READ:  state_nx_s = ST_WRITE;
      ST_WRITE: state_nx_s = (cnt_r == LW'(1)) ? ST_DONE : ST_READ;
      ST_SRD:   state_nx_s = ST_DONE;
      ST_SWR:   state_nx_s = ST_DONE;
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // State register, command capture, pointer/count stepping and read capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      src_ptr_r <= {AW{1'b0}};
      dst_ptr_r <= {AW{1'b0}};
      cnt_r     <= {LW{1'b0}};
      wval_r    <= {DW{1'b0}};
      buf_r     <= {DW{1'b0}};
      rdata_r   <= {DW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            src_ptr_r <= src;
            dst_ptr_r <= dst;
            cnt_r     <= len_clamp_s;
            wval_r    <= wdata;
          end
        end
        ST_FILL, ST_WRITE: begin
          dst_ptr_r <= dst_ptr_r + AW'(1);
          cnt_r     <= cnt_r - LW'(1);
        end
        ST_READ: begin
          buf_r     <= mem_dout;
          src_ptr_r <= src_ptr_r + AW'(1);
        end
        ST_SRD:  rdata_r <= mem_dout;
        default: ;
      endcase
    end
  end

  // Memory pins and status decoded from the current state.
  always_comb begin
    mem_addr = {AW{1'b0}};
    mem_din  = {DW{1'b0}};
    mem_en   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_r)
      ST_IDLE: busy = 1'b0;
      ST_FILL: begin
        mem_addr = dst_ptr_r;
        mem_din  = wval_r;
        mem_en   = 1'b1;
      end
      ST_READ: mem_addr = src_ptr_r;
      ST_WRITE: begin
        mem_addr = dst_ptr_r;
        mem_din  = buf_r;
        mem_en   = 1'b1;
      end
      ST_SRD: mem_addr = src_ptr_r;
      ST_SWR: begin
        mem_addr = dst_ptr_r;
        mem_din  = wval_r;
        mem_en   = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign rdata = rdata_r;

endmodule

// File: tb/tb_mem_dma_engine.sv
// tb_mem_dma_engine
// Bench for mem_dma_engine with a 256x16 memory beside it. Commands update a
// word-level reference memory; expected writes and completions go into
// queues that a negedge monitor checks against the DUT.
module tb_mem_dma_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  src, dst;
  logic [8:0]  len;
  logic [15:0] wdata;
  logic        busy, done;
  logic [15:0] rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_din;
  logic        mem_en;
  logic [15:0] mem_dout;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];

  typedef struct { logic is_rd; logic [15:0] rd; int at; } done_t;
  typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
  done_t dq[$];
  wr_t   wq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  done_t mon_e;
  wr_t   mon_w;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // memory array: combinational read, write on the clock edge
  always @(posedge clk) if (mem_en) mem[mem_addr] <= mem_din;
  assign mem_dout = mem[mem_addr];

  mem_dma_engine dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src(src), .dst(dst),
    .len(len), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_en(mem_en), .mem_dout(mem_dout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every write and every done pulse must match the next expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en) begin
        if (wq.size() == 0) begin
          chk("unexpected_write_addr", {56'd0, mem_addr}, 64'hFFFF);
        end else begin
          mon_w = wq.pop_front();
          chk("wr_addr", {56'd0, mem_addr}, {56'd0, mon_w.a});
          chk("wr_data", {48'd0, mem_din}, {48'd0, mon_w.d});
        end
      end
      if (done) begin
        done_cnt++;
        if (dq.size() == 0) begin
          chk("unexpected_done_cycle", 64'(cyc), 64'hFFFF_FFFF);
        end else begin
          mon_e = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_e.at));
          chk("busy_at_done", {63'd0, busy}, 64'd1);
          if (mon_e.is_rd) chk("rdata", {48'd0, rdata}, {48'd0, mon_e.rd});
        end
      end
    end
  end

  task automatic check_zero(input string name);
    chk(name, {21'd0, busy, done, rdata, mem_en, mem_addr, mem_din}, 64'd0);
  endtask

  task automatic mem_compare(input string name);
    int diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk(name, 64'(diffs), 64'd0);
  endtask

  // issue one command, apply it to the reference model, wait for completion
  task automatic issue(input logic [1:0] o, input logic [7:0] s, input logic [7:0] d,
                       input logic [8:0] l, input logic [15:0] wd);
    int n, lat, target;
    logic [7:0] a;
    logic [15:0] v, rdv;
    @(negedge clk);
    op = o; src = s; dst = d; len = l; wdata = wd; start = 1'b1;
    n = (l > 9'd256) ? 256 : int'(l);
    rdv = 16'd0;
    case (o)
      2'd0: begin
        for (int i = 0; i < n; i++) begin
          a = d + 8'(i);
          ref_mem[a] = wd;
          wq.push_back('{a, wd});
        end
        lat = (n == 0) ? 1 : n + 1;
      end
      2'd1: begin
        for (int i = 0; i < n; i++) begin
          v = ref_mem[8'(s + 8'(i))];
          a = d + 8'(i);
          ref_mem[a] = v;
          wq.push_back('{a, v});
        end
        lat = (n == 0) ? 1 : 2 * n + 1;
      end
      2'd2: begin
        rdv = ref_mem[s];
        lat = 2;
      end
      default: begin
        ref_mem[d] = wd;
        wq.push_back('{d, wd});
        lat = 2;
      end
    endcase
    target = done_cnt + 1;
    dq.push_back('{o == 2'd2, rdv, cyc + lat});
    // a start pulse while busy must be ignored
    @(negedge clk);
    op = 2'($urandom_range(0, 3)); src = 8'($urandom); dst = 8'($urandom);
    len = 9'($urandom_range(1, 5)); wdata = 16'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2000 && done_cnt < target; k++) @(negedge clk);
    if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
    @(negedge clk);
    chk("busy_low_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; src = 8'd0; dst = 8'd0; len = 9'd0; wdata = 16'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'd0;
    #1 check_zero("reset_outputs_async");
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    rst = 1'b0;

    issue(2'd0, 8'h00, 8'h00, 9'd256, 16'h0000);   // clear whole memory
    mem_compare("mem_after_clear");

    issue(2'd3, 8'h00, 8'h10, 9'd0, 16'hA5A5);     // WR
    issue(2'd2, 8'h10, 8'h00, 9'd0, 16'h0000);     // RD
    issue(2'd0, 8'h00, 8'h20, 9'd8, 16'h1234);     // FILL 8
    mem_compare("mem_after_fill8");

    for (int i = 0; i < 4; i++) issue(2'd3, 8'h00, 8'(8'h40 + i), 9'd0, 16'(i + 1));
    issue(2'd1, 8'h40, 8'h80, 9'd4, 16'h0000);     // COPY 4
    mem_compare("mem_after_copy4");

    issue(2'd0, 8'h00, 8'hFE, 9'd4, 16'h00FF);     // wrapping FILL
    issue(2'd0, 8'h00, 8'h50, 9'd0, 16'hDEAD);     // len=0
    mem_compare("mem_after_wrap");

    issue(2'd3, 8'h00, 8'h00, 9'd0, 16'd7);        // overlap replication
    issue(2'd0, 8'h00, 8'h01, 9'd3, 16'd0);
    issue(2'd1, 8'h00, 8'h01, 9'd3, 16'd0);
    for (int i = 1; i < 4; i++) issue(2'd2, 8'(i), 8'h00, 9'd0, 16'd0);
    issue(2'd1, 8'h60, 8'h60, 9'd5, 16'd0);        // src==dst
    issue(2'd0, 8'h00, 8'h90, 9'd300, 16'h5A5A);   // clamped to 256

    for (int t = 0; t < 40; t++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 9) == 0) ? 9'($urandom_range(257, 511)) : 9'($urandom_range(0, 12)),
            16'($urandom));
    end
    mem_compare("mem_after_random");

    // reset in the middle of a COPY of 6 words, after two words written
    @(negedge clk);
    op = 2'd1; src = 8'h30; dst = 8'hB0; len = 9'd6; wdata = 16'd0; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ref_mem[8'hB0 + i] = ref_mem[8'h30 + i];
      wq.push_back('{8'(8'hB0 + i), ref_mem[8'h30 + i]});
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 2'd3; dst = 8'hC7; wdata = 16'hBEEF; start = 1'b1;  // ignored while busy
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("reset_mid_copy");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mem_compare("mem_after_abort");
    issue(2'd2, 8'hB1, 8'h00, 9'd0, 16'd0);
    chk("write_queue_empty", 64'(wq.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
